// File: rtl/pc_gen_pkg.sv
// Shared types and default vectors for the fetch-PC generator.
// Imported by pc_gen and pc_perf_cnt.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        SEL_SEQ   = 2'd0,
        SEL_HOLD  = 2'd1,
        SEL_REDIR = 2'd2,
        SEL_TRAP  = 2'd3
    } npc_sel_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_1C00;

endpackage

// File: rtl/pc_perf_cnt.sv
// Enable-gated wrapping counter: one cycle from enable to updated count.
// No backpressure; counts whenever en_i is high outside reset.
module pc_perf_cnt
    import pc_gen_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: pc_o registered, npc_o combinational; one cycle per step.
// Stall or imem not-ready holds the PC; trap/redirect always win. Macro: PC_GEN_PERF_CNT_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEF_TRAP_VEC),
    parameter int              INST_BYTES = 4,
    parameter int              CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             stall_i,
    input  logic             fetch_ready_i,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    input  logic             trap_i,
    input  logic             halt_i,
    input  logic             retire_i,
    output logic [XLEN-1:0]  pc_o,
    output logic             pc_valid_o,
    output logic [XLEN-1:0]  npc_o,
    output logic             misalign_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instret_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);
    localparam logic [XLEN-1:0] INC        = XLEN'(INST_BYTES);

    pc_state_e       state_q, state_d;
    npc_sel_e        sel_d;
    logic [XLEN-1:0] pc_q;
    logic            pc_valid_q;
    logic            halted_q;
    logic            misalign_q, misalign_d;
    logic            hold;
    logic            redir_misal;
    logic            stall_en;

    assign hold        = stall_i || !fetch_ready_i;
    assign redir_misal = (redirect_pc_i & ALIGN_MASK) != '0;

    always_comb begin
        state_d    = state_q;
        sel_d      = SEL_HOLD;
        misalign_d = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, HALT: begin
                // Trap and redirect share handling in both states; they also pull HALT back to RUN.
                if (trap_i) begin
                    sel_d   = SEL_TRAP;
                    state_d = RUN;
                end else if (redirect_i) begin
                    state_d = RUN;
                    if (redir_misal) begin
                        sel_d      = SEL_TRAP;
                        misalign_d = 1'b1;
                    end else begin
                        sel_d = SEL_REDIR;
                    end
                end else if (state_q == HALT || halt_i) begin
                    sel_d   = SEL_HOLD;
                    state_d = HALT;
                end else if (hold) begin
                    sel_d = SEL_HOLD;
                end else begin
                    sel_d = SEL_SEQ;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_comb begin
        npc_o = pc_q;
        case (sel_d)
            SEL_SEQ:   npc_o = pc_q + INC;
            SEL_HOLD:  npc_o = pc_q;
            SEL_REDIR: npc_o = redirect_pc_i;
            SEL_TRAP:  npc_o = TRAP_VEC;
            default:   npc_o = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= npc_o;
            pc_valid_q <= (state_d == RUN);
            halted_q   <= (state_d == HALT);
            misalign_q <= misalign_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = pc_valid_q;
    assign halted_o   = halted_q;
    assign misalign_o = misalign_q;

    assign stall_en = (state_q == RUN) && !trap_i && !redirect_i && hold;

    pc_perf_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .en_i  (1'b1),
        .cnt_o (cycle_cnt_o)
    );

`ifdef PC_GEN_PERF_CNT_EN
    pc_perf_cnt #(.CNT_W(CNT_W)) u_instret_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .en_i  (retire_i),
        .cnt_o (instret_cnt_o)
    );

    pc_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .en_i  (stall_en),
        .cnt_o (stall_cnt_o)
    );
`else
    logic unused_perf;
    assign unused_perf   = retire_i ^ stall_en;
    assign instret_cnt_o = '0;
    assign stall_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expected values queued at drive time, popped when outputs are sampled.
module tb_pc_gen;

`ifdef PC_GEN_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall_i = 1'b0;
    logic        fetch_ready_i = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        trap_i = 1'b0;
    logic        halt_i = 1'b0;
    logic        retire_i = 1'b0;
    logic [31:0] pc_o, npc_o, cycle_cnt_o, instret_cnt_o, stall_cnt_o;
    logic        pc_valid_o, misalign_o, halted_o;

    pc_gen dut (
        .clk           (clk),
        .rstn          (rstn),
        .stall_i       (stall_i),
        .fetch_ready_i (fetch_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .trap_i        (trap_i),
        .halt_i        (halt_i),
        .retire_i      (retire_i),
        .pc_o          (pc_o),
        .pc_valid_o    (pc_valid_o),
        .npc_o         (npc_o),
        .misalign_o    (misalign_o),
        .halted_o      (halted_o),
        .cycle_cnt_o   (cycle_cnt_o),
        .instret_cnt_o (instret_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          ncmp = 0;
    int          nerr = 0;
    int          cyc  = 0;
    logic [31:0] exp_stall = '0;
    logic [31:0] exp_inst  = '0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        ncmp++;
        if (sb.size() == 0) begin
            nerr++;
            $error("FAIL scoreboard_empty observed=%h required=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                nerr++;
                $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Sample one cycle later, #1 past the active edge.
    task automatic tick();
        @(posedge clk);
        if (rstn) cyc++;
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        push("rst_pc", 32'h0);  push("rst_valid", 32'h0); push("rst_halted", 32'h0);
        push("rst_misal", 32'h0); push("rst_cycle", 32'h0);
        chk(pc_o); chk({31'h0, pc_valid_o}); chk({31'h0, halted_o});
        chk({31'h0, misalign_o}); chk(cycle_cnt_o);

        // Release: BOOT cycle, then sequential fetch
        rstn = 1'b1;
        #1;
        push("boot_valid", 32'h0); push("boot_pc", 32'h0);
        chk({31'h0, pc_valid_o}); chk(pc_o);
        push("seq0_pc", 32'h0); push("seq0_valid", 32'h1);
        tick(); chk(pc_o); chk({31'h0, pc_valid_o});
        push("seq1_pc", 32'h4); tick(); chk(pc_o);
        push("seq2_pc", 32'h8); tick(); chk(pc_o);
        push("cycle_after3", 32'(cyc)); chk(cycle_cnt_o);
        push("seq3_pc", 32'hC);  tick(); chk(pc_o);
        push("seq4_pc", 32'h10); tick(); chk(pc_o);

        // Stall for three cycles
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push("stall_pc", 32'h10); tick(); chk(pc_o);
            if (PERF) exp_stall++;
        end
        push("stall_cnt3", exp_stall); chk(stall_cnt_o);
        stall_i = 1'b0;
        push("after_stall_pc", 32'h14); tick(); chk(pc_o);

        // imem not ready also holds
        fetch_ready_i = 1'b0;
        push("notrdy_pc", 32'h14); tick(); chk(pc_o);
        if (PERF) exp_stall++;
        fetch_ready_i = 1'b1;

        // Redirect overrides stall, not counted as stall
        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200;
        #1;
        push("npc_redirect", 32'h200); chk(npc_o);
        push("redir_pc", 32'h200); tick(); chk(pc_o);
        push("redir_stallcnt", exp_stall); chk(stall_cnt_o);
        stall_i = 1'b0;

        // Misaligned redirect traps and pulses misalign_o once
        redirect_pc_i = 32'h202;
        push("misal_pc", 32'h1C00); push("misal_pulse", 32'h1);
        tick(); chk(pc_o); chk({31'h0, misalign_o});
        redirect_i = 1'b0;
        push("misal_clear", 32'h0); push("post_trap_seq", 32'h1C04);
        tick(); chk({31'h0, misalign_o}); chk(pc_o);

        // Trap beats redirect
        trap_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h300;
        push("trap_prio_pc", 32'h1C00); push("trap_no_misal", 32'h0);
        tick(); chk(pc_o); chk({31'h0, misalign_o});
        trap_i = 1'b0;

        // Halt at 0x40; retire counts while halted; stall ignored
        redirect_pc_i = 32'h40;
        push("to40_pc", 32'h40); tick(); chk(pc_o);
        redirect_i = 1'b0; halt_i = 1'b1;
        push("halt_halted", 32'h1); push("halt_valid", 32'h0); push("halt_pc", 32'h40);
        tick(); chk({31'h0, halted_o}); chk({31'h0, pc_valid_o}); chk(pc_o);
        stall_i = 1'b1; fetch_ready_i = 1'b0; retire_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push("halt_frozen_pc", 32'h40); tick(); chk(pc_o);
            if (PERF) exp_inst++;
        end
        retire_i = 1'b0;
        push("halt_cycle", 32'(cyc)); chk(cycle_cnt_o);
        push("halt_instret", exp_inst); chk(instret_cnt_o);
        push("halt_stallcnt", exp_stall); chk(stall_cnt_o);

        // Redirect out of HALT; halt_i still high is ignored that cycle
        redirect_i = 1'b1; redirect_pc_i = 32'h80;
        push("resume_pc", 32'h80); push("resume_valid", 32'h1); push("resume_halted", 32'h0);
        tick(); chk(pc_o); chk({31'h0, pc_valid_o}); chk({31'h0, halted_o});
        halt_i = 1'b0; stall_i = 1'b0; fetch_ready_i = 1'b1;

        // Wrap at top of address space
        redirect_pc_i = 32'hFFFF_FFFC;
        push("top_pc", 32'hFFFF_FFFC); tick(); chk(pc_o);
        redirect_i = 1'b0;
        push("wrap_pc", 32'h0); tick(); chk(pc_o);

        // Async reset while a redirect is pending
        redirect_i = 1'b1; redirect_pc_i = 32'h500;
        #2;
        rstn = 1'b0;
        cyc = 0; exp_stall = '0; exp_inst = '0;
        #1;
        push("arst_pc", 32'h0); push("arst_valid", 32'h0); push("arst_cycle", 32'h0);
        push("arst_stall", 32'h0); push("arst_inst", 32'h0);
        chk(pc_o); chk({31'h0, pc_valid_o}); chk(cycle_cnt_o); chk(stall_cnt_o); chk(instret_cnt_o);
        tick();
        push("arst_hold_pc", 32'h0); chk(pc_o);
        redirect_i = 1'b0;
        rstn = 1'b1;
        push("rerun_pc", 32'h0); push("rerun_valid", 32'h1);
        tick(); chk(pc_o); chk({31'h0, pc_valid_o});

        if (sb.size() != 0) begin
            nerr++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised fetch-PC generator for the pipelined CPU, successor to the single-register PC.
- Holds the fetch PC and issues it to instruction memory with a valid/ready handshake.
- Supports stall, branch/jump redirect, trap vectoring and halt/resume.
- Keeps cycle, retired-instruction and stall counters for the debug/perf readout.

Parameters:
XLEN, 32, PC and address width.
RESET_VEC, 32'h0000_0000, PC value loaded on reset.
TRAP_VEC, 32'h0000_1C00, PC loaded on trap or misaligned redirect.
INST_BYTES, 4, sequential increment; power of two, 2 or 4.
CNT_W, 32, width of every counter.

Ports:
clk  input  1  clock.
rstn  input  1  asynchronous active-low reset.
stall_i  input  1  pipeline stall; hold PC.
fetch_ready_i  input  1  imem accepts pc_o this cycle.
redirect_i  input  1  branch/jump taken.
redirect_pc_i  input  XLEN  redirect target.
trap_i  input  1  exception; go to TRAP_VEC.
halt_i  input  1  request halt.
retire_i  input  1  one instruction retired this cycle.
pc_o  output  XLEN  current fetch PC.
pc_valid_o  output  1  pc_o is a valid fetch request.
npc_o  output  XLEN  PC selected for the next cycle (combinational).
misalign_o  output  1  one-cycle pulse on misaligned redirect.
halted_o  output  1  block is in HALT.
cycle_cnt_o  output  CNT_W  cycles since reset.
instret_cnt_o  output  CNT_W  retired instructions.
stall_cnt_o  output  CNT_W  cycles where a fetch was held.

Behaviour:
- Reset state: rstn=0 asynchronously sets pc_o=RESET_VEC, state=BOOT, and all counters, misalign_o, pc_valid_o and halted_o to 0. Reset mid-operation discards any pending redirect or trap.
- State machine has three states: BOOT, RUN, HALT.
- BOOT:
  - pc_valid_o=0.
  - Next cycle goes to RUN unconditionally. This is the first edge after rstn deasserts, so the first valid fetch appears one cycle after reset release.
- RUN:
  - pc_valid_o=1.
  - npc_o is chosen by strict priority: trap_i > redirect_i > hold > sequential.
    1. trap_i=1: npc_o=TRAP_VEC.
    2. redirect_i=1 with redirect_pc_i aligned to INST_BYTES: npc_o=redirect_pc_i.
    3. redirect_i=1 with a misaligned target: npc_o=TRAP_VEC, and misalign_o=1 on the following cycle.
    4. Hold, when stall_i=1 or fetch_ready_i=0: npc_o=pc_o.
    5. Otherwise: npc_o=pc_o+INST_BYTES, wrapping modulo 2^XLEN with no flag.
  - Trap and redirect override stall and a not-ready imem, so a redirect is never lost. Hold only blocks sequential advance.
  - pc_o <= npc_o on every clock edge.
  - halt_i=1 with no trap or redirect: pc_o holds and state goes to HALT. If trap or redirect is asserted in the same cycle as halt_i, it wins and halt_i is ignored for that cycle.
- HALT:
  - pc_valid_o=0 and halted_o=1. pc_o is frozen and stall_i/fetch_ready_i are ignored.
  - trap_i or redirect_i loads the target as in RUN and returns to RUN; halt_i is then ignored.
- Counters:
  - cycle_cnt_o increments every cycle outside reset, including in BOOT and HALT.
  - instret_cnt_o increments when retire_i=1, in any state.
  - stall_cnt_o increments in RUN when hold applies and there is no trap or redirect.
  - All counters wrap at 2^CNT_W.
- misalign_o is registered: a one-cycle pulse, cleared the next cycle unless it fires again.

Optional Feature:
Macro PC_GEN_PERF_CNT_EN.
- Defined: instret_cnt_o and stall_cnt_o are implemented as described.
- Undefined: those two outputs are tied to 0 with no flops. cycle_cnt_o is always present.

Decomposition:
Shared package pc_gen_pkg holds:
- the state enum (BOOT, RUN, HALT);
- the next-PC select encoding (SEL_SEQ, SEL_HOLD, SEL_REDIR, SEL_TRAP);
- the default vector constants.

One sub-module, pc_perf_cnt: a CNT_W-wide enable-gated wrapping counter, instantiated three times (once per counter).

Test Plan:
1. Reset, release, fetch_ready_i=1 -> cycle 1: pc_valid_o=0, pc_o=0. Cycles 2-4: pc_o = 0, 4, 8, with pc_valid_o=1.
2. pc_o=0x10, stall_i=1 for 3 cycles -> pc_o stays 0x10, stall_cnt_o=3, then advances to 0x14.
3. stall_i=1 with redirect_i=1, redirect_pc_i=0x200 -> next pc_o=0x200, stall_cnt_o unchanged.
4. redirect_pc_i=0x202 -> next pc_o=TRAP_VEC (0x1C00) and misalign_o=1 for exactly one cycle. trap_i and redirect_i together -> TRAP_VEC.
5. halt_i=1 at pc_o=0x40 -> halted_o=1, pc_valid_o=0, pc_o frozen while cycle_cnt_o keeps counting. redirect to 0x80 -> RUN, pc_o=0x80.
6. pc_o=0xFFFF_FFFC, sequential -> wraps to 0x0. Assert rstn=0 during a pending redirect -> pc_o=RESET_VEC and all counters 0. With PC_GEN_PERF_CNT_EN undefined -> instret_cnt_o stays 0.
